delay_commutator: RTL
=====================

# delay_commutator

Four-lane delay-commutator that performs the inter-stage group transpose in the radix-16 16384-point pipeline. Each lane is a P_WIDTH sample stream. Over every block of 4·D input cycles, the block exchanges D-sample groups between lanes: output lane j, group g equals input lane g, group j. It sits directly upstream of the per-lane 0/4/8/12-cycle alignment FIFOs and feeds them lane-transposed data. The whole datapath stalls on in_valid.

## Interface
- P_WIDTH, 64, sample width per lane
- D, 4, group length in samples; power of two, ≥1
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  advance enable; the datapath moves only when high
- in_first  in  1  qualified by in_valid; marks the first sample of a 4·D block
- in_d0, in_d1, in_d2, in_d3  in  P_WIDTH each  input lanes 0..3
- out_valid  out  1  registered; output lanes hold valid transposed data
- out_d0, out_d1, out_d2, out_d3  out  P_WIDTH each  output lanes 0..3, registered

## Operation
- An advance is a cycle with in_valid=1. Nothing changes state without an advance: delay lines, counter, primed flag and output registers all hold.
- Pre-delay: input lane i passes through an enabled delay line of i·D stages. Depths are 0, D, 2D and 3D.
- Phase counter cnt is log2(4D) bits wide.
  - It increments on every advance and wraps at 4D−1 → 0.
  - If in_valid and in_first are both high, the value used this cycle is 0 and the next value is 1.
  - in_first is ignored when in_valid=0.
  - Phase s = cnt[top 2 bits] (0..3).
- Switch (combinational): position j takes pre-delayed lane (s − j) mod 4.
- Post-delay: switch position j passes through an enabled delay line of (3−j)·D stages. Depths are 3D, 2D, D and 0.
- Output registers load the post-delayed values on each advance.
  - out_valid ← in_valid ∧ primed.
  - out_valid ← 0 on a non-advance cycle; out_d* hold their values.
- primed: a fill counter counts advances since reset and saturates. primed=1 once 3D advances have completed.
  - The primed flag is not cleared by in_first.
  - The first 3D outputs after reset are flushed zeros, with out_valid=0.
- Mapping for a block whose first sample arrives at advance a:
  - Define x_i[n] as input lane i at advance a+n, for n = 0..4D−1.
  - Output lane j at advance a+3D+m equals x_{m/D}[D·j + (m mod D)], for m = 0..4D−1.
- Back-to-back blocks stream with no bubbles.
- An in_first pulse in mid-block re-phases the counter. The data of the interrupted block is then corrupt, and nothing flags it.
- Reset state: all delay stages 0, cnt=0, fill counter 0, primed=0, out_d*=0, out_valid=0.
- Reset asserted mid-operation clears everything immediately, asynchronously. The next block requires in_first.

## Timing
- Latency: 3D advances from the input sample to the matching switch output, then 1 cycle for the output register. With continuous in_valid, the first output of a block appears 3D+1 clocks after its in_first.
- Throughput: 4 samples per advance, no back-pressure input.
- Stall cycles insert the same number of clocks into the latency and leave the data alignment unchanged.
- Combinational path: delay-line tap → 4:1 mux → post-delay stage 0. No input-to-output combinational path.

## Structure
- Shared package: NUM_LANES=4; phase width function clog2(4·D); lane index and phase typedefs.
- Sub-module en_delay_line (parameters P_WIDTH, DEPTH):
  - shift-enabled register chain with async-reset stages;
  - DEPTH=0 is a wire passthrough.
  - Instantiated 8 times, 4 pre-delay and 4 post-delay.
- The top level holds cnt, the fill counter, the switch mux and the output registers.

## Test plan
- Encoding: D=4, input lane i, sample n carries the value 16i+n. Continuous valid, in_first at n=0, for one block.
  - out_valid first rises 13 clocks after in_first.
  - Lane 0 then outputs 0,1,2,3,16,17,18,19,32,33,34,35,48,49,50,51.
  - Lane 1 outputs 4..7, 20..23, 36..39, 52..55.
  - Lane 3 outputs 12..15, 28..31, 44..47, 60..63.
- Two back-to-back blocks, the second offset by +64: outputs are contiguous with no gap, and the second block's lane 0 starts at 64.
- Same stimulus with in_valid pseudo-randomly low about 30% of cycles: the valid outputs give an identical value sequence. out_valid=0 on every stall cycle, and out_d* hold.
- Reset deasserted: out_d*=0, out_valid=0. The first 12 advances give out_valid=0.
- rst_n pulsed low at block cycle 7: all outputs 0 at once. A new in_first block afterwards produces the correct mapping, with first valid output 13 clocks after it.
- D=1 parameterisation, encoding 4i+n: lane j outputs j, 4+j, 8+j, 12+j (4×4 sample transpose), with latency 4 clocks.

Source files
------------

// File: rtl/delay_commutator_pkg.sv
// Shared definitions for the four-lane delay commutator.
package delay_commutator_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_idx_t;
  typedef logic [1:0] phase_t;

  function automatic int phase_width(input int d);
    return $clog2(4 * d);
  endfunction

endpackage

// File: rtl/en_delay_line.sv
// Shift-enabled register chain of DEPTH stages; DEPTH=0 is a plain wire.
module en_delay_line #(
  parameter int P_WIDTH = 64,
  parameter int DEPTH   = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [P_WIDTH-1:0] din,
  output logic [P_WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst_n, en};
      assign dout = din;
    end else begin : g_chain
      logic [P_WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < DEPTH; k++) stage[k] <= '0;
        end else if (en) begin
          stage[0] <= din;
          for (int k = 1; k < DEPTH; k++) stage[k] <= stage[k-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/delay_commutator.sv
// Four-lane delay commutator: swaps D-sample groups between lanes over each 4*D block.
module delay_commutator
  import delay_commutator_pkg::*;
#(
  parameter int P_WIDTH = 64,
  parameter int D       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic               in_first,
  input  logic [P_WIDTH-1:0] in_d0,
  input  logic [P_WIDTH-1:0] in_d1,
  input  logic [P_WIDTH-1:0] in_d2,
  input  logic [P_WIDTH-1:0] in_d3,
  output logic               out_valid,
  output logic [P_WIDTH-1:0] out_d0,
  output logic [P_WIDTH-1:0] out_d1,
  output logic [P_WIDTH-1:0] out_d2,
  output logic [P_WIDTH-1:0] out_d3
);

  localparam int CW = phase_width(D);
  localparam int FW = $clog2(3 * D + 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(3 * D);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_now;
  phase_t        s;
  logic [FW-1:0] fill;
  logic          primed;

  logic [P_WIDTH-1:0] pre_in   [NUM_LANES];
  logic [P_WIDTH-1:0] pre_out  [NUM_LANES];
  logic [P_WIDTH-1:0] sw       [NUM_LANES];
  logic [P_WIDTH-1:0] post_out [NUM_LANES];

  // in_first forces phase 0 in the same cycle it is seen
  assign cnt_now = (in_valid && in_first) ? '0 : cnt;
  assign s       = cnt_now[CW-1 -: 2];
  assign primed  = (fill == FILL_MAX);

  assign pre_in[0] = in_d0;
  assign pre_in[1] = in_d1;
  assign pre_in[2] = in_d2;
  assign pre_in[3] = in_d3;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      en_delay_line #(.P_WIDTH(P_WIDTH), .DEPTH(gi * D)) u_pre (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (in_valid),
        .din  (pre_in[gi]),
        .dout (pre_out[gi])
      );

      en_delay_line #(.P_WIDTH(P_WIDTH), .DEPTH((3 - gi) * D)) u_post (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (in_valid),
        .din  (sw[gi]),
        .dout (post_out[gi])
      );
    end
  endgenerate

  always_comb begin
    for (int j = 0; j < NUM_LANES; j++) begin
      sw[j] = pre_out[lane_idx_t'(s - lane_idx_t'(j))];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_d0    <= '0;
      out_d1    <= '0;
      out_d2    <= '0;
      out_d3    <= '0;
    end else begin
      out_valid <= in_valid && primed;
      if (in_valid) begin
        cnt    <= cnt_now + CW'(1);
        out_d0 <= post_out[0];
        out_d1 <= post_out[1];
        out_d2 <= post_out[2];
        out_d3 <= post_out[3];
        if (!primed) fill <= fill + FW'(1);
      end
    end
  end

endmodule
